// File: rtl/pll_pkg.sv
// pll_pkg -- shared types and sizing helpers for the PLL phase-step controller.
//   pll_state_t    : controller FSM states
//   SEL_W          : width of the PHASESEL output / request select field
//   RELOCK_W       : width of the saturating lock-loss counter
//   cnt_width()    : counter width able to hold the largest timing parameter
//   is_run_state() : states in which the PLL is considered locked and usable
package pll_pkg;

    typedef enum logic [2:0] {
        PRST,
        WLOCK,
        STABLE,
        IDLE,
        STEP_LO,
        STEP_HI,
        LOAD_LO,
        LOAD_HI
    } pll_state_t;

    localparam int SEL_W    = 2;
    localparam int RELOCK_W = 8;
    localparam logic [RELOCK_W-1:0] RELOCK_MAX = '1;

    // Width needed to count up to the largest of the timing parameters.
    function automatic int cnt_width(input int rst_cyc, input int lock_wait,
                                     input int lock_tmo, input int pulse_cyc);
        int m;
        m = rst_cyc;
        if (lock_wait > m) m = lock_wait;
        if (lock_tmo > m)  m = lock_tmo;
        if (pulse_cyc > m) m = pulse_cyc;
        return $clog2(m + 1);
    endfunction

    // Counter width for the default parameter set.
    localparam int CNT_W_DEFAULT = $clog2(65536 + 1);

    // IDLE and the stepping states all require a held lock.
    function automatic logic is_run_state(input pll_state_t s);
        return (s == IDLE) || (s == STEP_LO) || (s == STEP_HI) ||
               (s == LOAD_LO) || (s == LOAD_HI);
    endfunction

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// pll_phase_ctrl_if -- phase-step request handshake.
//   req_valid : requester has a phase-step command
//   req_ready : controller can accept a command this cycle
//   req_sel   : PLL output to step
//   req_dir   : 1 = lag, 0 = lead
//   req_steps : number of phase steps (0 = no-op that still completes)
// master = requester, slave = pll_phase_ctrl.
interface pll_phase_ctrl_if
    import pll_pkg::*;
#(
    parameter int STEP_W = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [SEL_W-1:0]  req_sel;
    logic              req_dir;
    logic [STEP_W-1:0] req_steps;

    modport master (output req_valid, req_sel, req_dir, req_steps,
                    input  req_ready);
    modport slave  (input  req_valid, req_sel, req_dir, req_steps,
                    output req_ready);
endinterface

// File: rtl/sync2.sv
// sync2 -- two-flop synchroniser for a single asynchronous level.
//   clk : destination clock
//   rst : synchronous active-high reset (output forced low)
//   d   : asynchronous input
//   q   : synchronised output, two clk cycles of latency
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];
endmodule

// File: rtl/pll_phase_ctrl.sv
// pll_phase_ctrl -- brings a PLL out of reset, waits for a stable lock, then
// executes dynamic phase-step requests (PHASESTEP pulses followed by a
// PHASELOADREG pulse). A lock loss while usable resets the PLL again.
//   clk, rst        : clock and synchronous active-high reset
//   pll_lock        : asynchronous LOCK from the PLL
//   pll_rst         : RST to the PLL
//   phasesel/dir    : PHASESEL[1:0] / PHASEDIR to the PLL
//   phasestep       : PHASESTEP, idles high, low half of each step
//   phaseloadreg    : PHASELOADREG, idles high, one low pulse per request
//   req             : request handshake (slave side)
//   ready           : lock stable, requests can be served
//   done / err      : one-cycle completion / illegal-request pulses
//   relock_cnt      : saturating count of lock losses
module pll_phase_ctrl
    import pll_pkg::*;
#(
    parameter int NUM_OUT   = 4,
    parameter int STEP_W    = 4,
    parameter int PULSE_CYC = 4,
    parameter int RST_CYC   = 16,
    parameter int LOCK_WAIT = 1024,
    parameter int LOCK_TMO  = 65536
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_lock,
    output logic                pll_rst,
    output logic [SEL_W-1:0]    phasesel,
    output logic                phasedir,
    output logic                phasestep,
    output logic                phaseloadreg,
    pll_phase_ctrl_if.slave     req,
    output logic                ready,
    output logic                done,
    output logic                err,
    output logic [RELOCK_W-1:0] relock_cnt
);
    localparam int CNT_W = cnt_width(RST_CYC, LOCK_WAIT, LOCK_TMO, PULSE_CYC);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(LOCK_TMO - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);

    pll_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CNT_W-1:0]  tmo_reg, tmo_next;
    logic [STEP_W-1:0] step_reg, step_next;
    logic [SEL_W-1:0]  sel_reg, sel_next;
    logic              dir_reg, dir_next;
    logic              done_next, err_next, lock_lost;

    logic                pll_rst_reg, phasestep_reg, phaseload_reg;
    logic                ready_reg, req_ready_reg, done_reg, err_reg;
    logic [RELOCK_W-1:0] relock_reg;
    logic                lk;
    logic                accept;

    sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lk)
    );

    assign accept = req.req_valid && req_ready_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        tmo_next   = tmo_reg;
        step_next  = step_reg;
        sel_next   = sel_reg;
        dir_next   = dir_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        lock_lost  = 1'b0;

        case (state_reg)
            PRST: begin
                tmo_next = '0;
                if (cnt_reg == RST_LAST) begin
                    state_next = WLOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            // The timeout keeps counting across STABLE->WLOCK bounces so a
            // chattering lock still ends in a fresh PLL reset.
            WLOCK: begin
                if (lk) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (tmo_reg == TMO_LAST) begin
                    state_next = PRST;
                    cnt_next   = '0;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_next = WLOCK;
                end else if (cnt_reg == WAIT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            IDLE: begin
                if (accept) begin
                    if (int'(req.req_sel) >= NUM_OUT) begin
                        err_next = 1'b1;
                    end else if (req.req_steps == '0) begin
                        done_next = 1'b1;
                    end else begin
                        sel_next   = req.req_sel;
                        dir_next   = req.req_dir;
                        step_next  = req.req_steps;
                        cnt_next   = '0;
                        state_next = STEP_LO;
                    end
                end
            end
            STEP_LO: begin
                if (cnt_reg == PULSE_LAST) begin
                    state_next = STEP_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            STEP_HI: begin
                if (cnt_reg == PULSE_LAST) begin
                    cnt_next   = '0;
                    step_next  = (step_reg != '0) ? step_reg - 1'b1 : step_reg;
                    state_next = (step_reg <= STEP_W'(1)) ? LOAD_LO : STEP_LO;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            LOAD_LO: begin
                if (cnt_reg == PULSE_LAST) begin
                    state_next = LOAD_HI;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            LOAD_HI: begin
                if (cnt_reg == PULSE_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = PRST;
                cnt_next   = '0;
            end
        endcase

        // Lock loss while usable overrides everything, including a request
        // arriving in the same cycle.
        if (is_run_state(state_reg) && !lk) begin
            state_next = PRST;
            cnt_next   = '0;
            done_next  = 1'b0;
            err_next   = 1'b0;
            lock_lost  = 1'b1;
        end
    end

    // Outputs are registered from the next state so the PLL control pins
    // never see decode glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= PRST;
            cnt_reg       <= '0;
            tmo_reg       <= '0;
            step_reg      <= '0;
            sel_reg       <= '0;
            dir_reg       <= 1'b0;
            pll_rst_reg   <= 1'b1;
            phasestep_reg <= 1'b1;
            phaseload_reg <= 1'b1;
            ready_reg     <= 1'b0;
            req_ready_reg <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            relock_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            tmo_reg       <= tmo_next;
            step_reg      <= step_next;
            sel_reg       <= sel_next;
            dir_reg       <= dir_next;
            pll_rst_reg   <= (state_next == PRST);
            phasestep_reg <= (state_next != STEP_LO);
            phaseload_reg <= (state_next != LOAD_LO);
            ready_reg     <= is_run_state(state_next);
            req_ready_reg <= (state_next == IDLE);
            done_reg      <= done_next;
            err_reg       <= err_next;
            if (lock_lost && (relock_reg != RELOCK_MAX)) begin
                relock_reg <= relock_reg + 1'b1;
            end
        end
    end

    assign pll_rst       = pll_rst_reg;
    assign phasesel      = sel_reg;
    assign phasedir      = dir_reg;
    assign phasestep     = phasestep_reg;
    assign phaseloadreg  = phaseload_reg;
    assign req.req_ready = req_ready_reg;
    assign ready         = ready_reg;
    assign done          = done_reg;
    assign err           = err_reg;
    assign relock_cnt    = relock_reg;
endmodule
